sync_fifo_flags: RTL and testbench

- Single-clock, parametrised FIFO; the successor to the dual-clock FIFO for paths where producer and consumer share one clock.
- Beyond plain full/empty it adds:
  - programmable almost-full and almost-empty thresholds
  - a fill-level count
  - sticky overflow and underflow error flags
  - a synchronous flush
- Sits between a producer and a consumer block in the same clock domain, using the same write_en/read_en handshake as the async FIFO.

---
 rtl/sync_fifo_flags.sv | 134 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags
// and a synchronous flush.
//
// Optional build macro: FWFT_EN (first-word fall-through). When defined,
// read_data shows mem[rptr] combinationally and read_en acknowledges the
// head word. When undefined, read_data is registered one cycle after the
// accepting edge.
//
// Ports:
//   clk          clock, all state changes on rising edge
//   rst_n        synchronous active-low reset
//   flush        synchronous flush (empties FIFO, ignores write/read)
//   clear_err    clears sticky overflow/underflow
//   write_en     write request,  write_data word to push
//   read_en      read request,   read_data popped word
//   fifo_empty   fill_count == 0
//   fifo_full    fill_count == depth
//   almost_full  fill_count >= almost_full_th
//   almost_empty fill_count <= almost_empty_th
//   fill_count   stored words, 0..depth
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module sync_fifo_flags #(
  parameter int data_size       = 8,
  parameter int addr_size       = 3,
  parameter int almost_full_th  = 6,
  parameter int almost_empty_th = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 clear_err,
  input  logic                 write_en,
  input  logic [data_size-1:0] write_data,
  input  logic                 read_en,
  output logic [data_size-1:0] read_data,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [addr_size:0]   fill_count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned depth = 1 << addr_size;
  localparam int          CW    = addr_size + 1;

  localparam logic [addr_size:0] FULL_CNT = CW'(depth);
  localparam logic [addr_size:0] AF_CNT   = CW'(almost_full_th);
  localparam logic [addr_size:0] AE_CNT   = CW'(almost_empty_th);

  logic [data_size-1:0] mem [depth];
  logic [addr_size:0]   wptr;
  logic [addr_size:0]   rptr;
  logic [addr_size:0]   count;

  logic rd_acc;
  logic wr_acc;
  logic ov_evt;
  logic un_evt;

  assign fill_count   = count;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A write while full is still accepted when a read frees the head slot in
  // the same edge; a read while empty is never bypassed from the write.
  always_comb begin
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    ov_evt = 1'b0;
    un_evt = 1'b0;
    if (!flush) begin
      rd_acc = read_en && !fifo_empty;
      wr_acc = write_en && (!fifo_full || rd_acc);
      ov_evt = write_en && !wr_acc;
      un_evt = read_en && fifo_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wptr[addr_size-1:0]] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A new error in the same cycle as clear_err keeps the flag set.
      overflow  <= (overflow  && !clear_err) || ov_evt;
      underflow <= (underflow && !clear_err) || un_evt;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + 1'b1;
        if (rd_acc) rptr <= rptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef FWFT_EN
  assign read_data = mem[rptr[addr_size-1:0]];
`else
  logic [data_size-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_acc) begin
      rd_q <= mem[rptr[addr_size-1:0]];
    end
  end

  assign read_data = rd_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       clear_err;
  logic       write_en;
  logic [7:0] write_data;
  logic       read_en;
  logic [7:0] read_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fill_count;
  logic       overflow;
  logic       underflow;

  sync_fifo_flags #(
    .data_size(8),
    .addr_size(3),
    .almost_full_th(AF_TH),
    .almost_empty_th(AE_TH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .clear_err(clear_err),
    .write_en(write_en),
    .write_data(write_data),
    .read_en(read_en),
    .read_data(read_data),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .fill_count(fill_count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the last popped value.
  logic [7:0] q[$];
  logic [7:0] m_rd;
  logic       m_ov;
  logic       m_un;
  bit         chk_en = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_rd = 8'h00;
      m_ov = 1'b0;
      m_un = 1'b0;
      chk_en = 1;
    end else if (flush) begin
      q.delete();
      if (clear_err) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end
    end else begin
      bit was_full, was_empty, do_rd, do_wr;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      do_rd = read_en && !was_empty;
      do_wr = write_en && (!was_full || do_rd);
      if (write_en && !do_wr) m_ov = 1'b1;
      else if (clear_err)     m_ov = 1'b0;
      if (read_en && was_empty) m_un = 1'b1;
      else if (clear_err)       m_un = 1'b0;
      if (do_rd) m_rd = q.pop_front();
      if (do_wr) q.push_back(write_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_fill_count",   32'(fill_count),   32'(q.size()));
      check("m_fifo_empty",   32'(fifo_empty),   32'(q.size() == 0));
      check("m_fifo_full",    32'(fifo_full),    32'(q.size() == DEPTH));
      check("m_almost_full",  32'(almost_full),  32'(q.size() >= AF_TH));
      check("m_almost_empty", 32'(almost_empty), 32'(q.size() <= AE_TH));
      check("m_read_data",    32'(read_data),    32'(m_rd));
      check("m_overflow",     32'(overflow),     32'(m_ov));
      check("m_underflow",    32'(underflow),    32'(m_un));
    end
  end

  // One clock: apply inputs, take the edge, return 1ns after it.
  task automatic step(input logic we, input logic [7:0] wd, input logic re,
                      input logic fl, input logic ce, input logic rn);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    flush      = fl;
    clear_err  = ce;
    rst_n      = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_fill"},   32'(fill_count),   32'd0);
    check({tag, "_empty"},  32'(fifo_empty),   32'd1);
    check({tag, "_full"},   32'(fifo_full),    32'd0);
    check({tag, "_ae"},     32'(almost_empty), 32'd1);
    check({tag, "_af"},     32'(almost_full),  32'd0);
    check({tag, "_rdata"},  32'(read_data),    32'd0);
    check({tag, "_ovf"},    32'(overflow),     32'd0);
    check({tag, "_unf"},    32'(underflow),    32'd0);
  endtask

  initial begin
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_state("reset");
    idle();

    // Fill with 0x11..0x18 and watch the threshold crossings.
    for (int i = 1; i <= 8; i++) begin
      wr(8'(8'h10 + i));
      if (i == 2) check("fill_ae_at2", 32'(almost_empty), 32'd1);
      if (i == 3) check("fill_ae_at3", 32'(almost_empty), 32'd0);
      if (i == 5) check("fill_af_at5", 32'(almost_full),  32'd0);
      if (i == 6) check("fill_af_at6", 32'(almost_full),  32'd1);
      if (i == 7) check("fill_full_at7", 32'(fifo_full),  32'd0);
    end
    check("fill_full", 32'(fifo_full),  32'd1);
    check("fill_cnt8", 32'(fill_count), 32'd8);

    wr(8'hAA);
    check("ovf_set",  32'(overflow),   32'd1);
    check("ovf_cnt",  32'(fill_count), 32'd8);

    for (int i = 1; i <= 8; i++) begin
      rd();
      check("drain1_data", 32'(read_data), 32'(8'h10 + i));
    end
    check("drain1_empty", 32'(fifo_empty), 32'd1);

    rd();
    check("unf_set",   32'(underflow), 32'd1);
    check("unf_rdata", 32'(read_data), 32'h18);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("unf_clr", 32'(underflow), 32'd0);
    check("ovf_clr", 32'(overflow),  32'd0);

    // Simultaneous write+read while full: count holds, new words queue behind.
    for (int i = 1; i <= 8; i++) wr(8'(8'h20 + i));
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0, 1'b1);
      check("simfull_cnt",  32'(fill_count), 32'd8);
      check("simfull_full", 32'(fifo_full),  32'd1);
      check("simfull_data", 32'(read_data),  32'(8'h20 + i));
      check("simfull_ovf",  32'(overflow),   32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      rd();
      check("drain2_data", 32'(read_data), (i < 5) ? 32'(8'h24 + i) : 32'(8'h31 + i - 5));
    end

    // Simultaneous write+read while empty: no bypass.
    step(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b1);
    check("simempty_cnt",   32'(fill_count), 32'd1);
    check("simempty_unf",   32'(underflow),  32'd1);
    check("simempty_rdata", 32'(read_data),  32'h33);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Overflow coinciding with clear_err stays set.
    for (int i = 0; i < 7; i++) wr(8'(8'h50 + i));
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovf_vs_clr", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovf_clr2", 32'(overflow), 32'd0);

    // Flush from full with write_en high: empties, no error flagged.
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_cnt",   32'(fill_count), 32'd0);
    check("flush_empty", 32'(fifo_empty), 32'd1);
    check("flush_ovf",   32'(overflow),   32'd0);
    check("flush_rdata", 32'(read_data),  32'h33);

    // Store 5, flush with write_en.
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    check("flush5_cnt", 32'(fill_count), 32'd0);
    check("flush5_unf", 32'(underflow),  32'd0);
    wr(8'h9A);
    rd();
    check("postflush_data", 32'(read_data), 32'h9A);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) wr(8'(8'h70 + i));
    rd();
    step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
    check_reset_state("midreset");
    idle();
    rd();
    check("midreset_unf", 32'(underflow), 32'd1);
    idle();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
